// File: rtl/dma_pair_feeder.sv
// Avalon-MM DMA master that streams operand pairs into the FP-add accelerator and stores the sums.
// Optional read-response watchdog: define DMA_FEEDER_TIMEOUT_EN.
module dma_pair_feeder #(
  parameter logic [31:0] ACC_BASE    = 32'h0000_1000,
  parameter int          CNT_W       = 16,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  input  logic        m_waitrequest,
  output logic        irq,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_WT_A, S_RD_B, S_WT_B, S_WR_A, S_WR_B,
    S_WR_GO, S_RD_RES, S_WT_RES, S_WR_RES, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_nx;
  logic [31:0]      src, dst, src_ptr, dst_ptr, op_a, op_b, res;
  logic [CNT_W-1:0] count, pairs;
  logic             irq_en, done, err;
  logic             busy, ctrl_wr, start_req, clr_req, timeout, last_pair, wr_res_ack;

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign ctrl_wr    = csr_write && (csr_address == 2'd3);
  assign start_req  = ctrl_wr && csr_writedata[0] && !busy;
  assign clr_req    = ctrl_wr && csr_writedata[2];
  assign last_pair  = ((pairs + CNT_ONE) == count);
  assign wr_res_ack = (state == S_WR_RES) && !m_waitrequest;
  assign irq        = done & irq_en;
  assign dbg_state  = state;

`ifdef DMA_FEEDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            in_wait;

  assign in_wait = (state == S_WT_A) || (state == S_WT_B) || (state == S_WT_RES);
  // Counts consecutive cycles spent waiting; the TIMEOUT_CYC-th such cycle aborts.
  assign timeout = in_wait && !m_readdatavalid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       to_cnt <= '0;
    else if (!in_wait || m_readdatavalid) to_cnt <= '0;
    else                                to_cnt <= to_cnt + TO_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Bus handshake: a command (m_read or m_write with address/data) is presented from the
  // state register and held unchanged while m_waitrequest is high; it is taken on the first
  // clock edge with m_waitrequest low. Read data is accepted only in WT_* on m_readdatavalid.
  always_comb begin
    state_nx    = state;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = 32'd0;
    m_writedata = 32'd0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start_req) state_nx = (count == '0) ? S_DONE : S_RD_A;
        else           state_nx = S_IDLE;
      end
      S_RD_A: begin
        m_read = 1'b1; m_address = src_ptr;
        if (!m_waitrequest) state_nx = S_WT_A;
      end
      S_WT_A: begin
        if (m_readdatavalid) state_nx = S_RD_B;
        else if (timeout)    state_nx = S_DONE;
      end
      S_RD_B: begin
        m_read = 1'b1; m_address = src_ptr + 32'd4;
        if (!m_waitrequest) state_nx = S_WT_B;
      end
      S_WT_B: begin
        if (m_readdatavalid) state_nx = S_WR_A;
        else if (timeout)    state_nx = S_DONE;
      end
      S_WR_A: begin
        m_write = 1'b1; m_address = ACC_BASE; m_writedata = op_a;
        if (!m_waitrequest) state_nx = S_WR_B;
      end
      S_WR_B: begin
        m_write = 1'b1; m_address = ACC_BASE + 32'd4; m_writedata = op_b;
        if (!m_waitrequest) state_nx = S_WR_GO;
      end
      S_WR_GO: begin
        m_write = 1'b1; m_address = ACC_BASE + 32'd12;
        if (!m_waitrequest) state_nx = S_RD_RES;
      end
      S_RD_RES: begin
        m_read = 1'b1; m_address = ACC_BASE + 32'd16;
        if (!m_waitrequest) state_nx = S_WT_RES;
      end
      S_WT_RES: begin
        if (m_readdatavalid) state_nx = S_WR_RES;
        else if (timeout)    state_nx = S_DONE;
      end
      S_WR_RES: begin
        m_write = 1'b1; m_address = dst_ptr; m_writedata = res;
        if (!m_waitrequest) state_nx = last_pair ? S_DONE : S_RD_A;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src <= '0; dst <= '0; count <= '0; irq_en <= 1'b0; done <= 1'b0; err <= 1'b0;
      pairs <= '0; src_ptr <= '0; dst_ptr <= '0; op_a <= '0; op_b <= '0; res <= '0;
      csr_readdata <= '0;
    end else begin
      if (csr_write && !busy) begin
        case (csr_address)
          2'd0:    src   <= csr_writedata;
          2'd1:    dst   <= {csr_writedata[31:2], 2'b00};
          2'd2:    count <= csr_writedata[CNT_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en <= csr_writedata[1];
      // Completion outranks a same-cycle clear, so clear+start with COUNT=0 still ends done.
      if (state_nx == S_DONE) done <= 1'b1;
      else if (clr_req)       done <= 1'b0;
      if (start_req)    err <= 1'b0;
      else if (timeout) err <= 1'b1;

      if (start_req) begin
        pairs   <= '0;
        src_ptr <= src;
        dst_ptr <= dst;
      end else begin
        if (state == S_WT_B && m_readdatavalid) src_ptr <= src_ptr + 32'd8;
        if (wr_res_ack) begin
          dst_ptr <= dst_ptr + 32'd4;
          pairs   <= pairs + CNT_ONE;
        end
      end
      if (state == S_WT_A   && m_readdatavalid) op_a <= m_readdata;
      if (state == S_WT_B   && m_readdatavalid) op_b <= m_readdata;
      if (state == S_WT_RES && m_readdatavalid) res  <= m_readdata;

      if (csr_read) begin
        case (csr_address)
          2'd0:    csr_readdata <= src;
          2'd1:    csr_readdata <= dst;
          2'd2:    csr_readdata <= 32'(count);
          default: csr_readdata <= {16'(pairs), 12'd0, err, done, irq_en, busy};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_pair_feeder.sv
// Bench for dma_pair_feeder: randomized Avalon slave + accelerator model, scoreboard of bus transactions.
module tb_dma_pair_feeder;
  localparam logic [31:0] ACC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_readdata, csr_writedata;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_read, m_write, m_readdatavalid, m_waitrequest, irq;
  logic [3:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int strobe_cycles = 0;
  int max_stall = 0;
  bit stray_en = 1'b0;
  bit drop_reads = 1'b0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] acc_a = 0, acc_b = 0, acc_res = 0;
  logic [64:0] exp_q[$];

  int          sl_stall = -1;
  int          sl_lat = 0;
  bit          sl_pend = 1'b0;
  logic [31:0] sl_data = 0;

  dma_pair_feeder dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
    .irq(irq), .dbg_state(dbg_state)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Single-precision add through double precision (truncating); operands are normal numbers.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) + sp2r(b));
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == ACC + 32'd16) return acc_res;
    if (mem.exists(a)) return mem[a];
    return 32'd0;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0]  e;
    logic [22:0] m;
    e = 8'($urandom_range(120, 134));
    m = 23'($urandom);
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    if (a == ACC)                 acc_a = d;
    else if (a == ACC + 32'd4)    acc_b = d;
    else if (a == ACC + 32'd12)   acc_res = fadd(acc_a, acc_b);
    else                          mem[a] = d;
  endtask

  // Avalon slave: random stalls, 0-2 cycle read latency, optional stray readdatavalid.
  initial begin
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      m_readdatavalid = 1'b0;
      if (!reset_n) begin
        sl_pend = 1'b0; sl_stall = -1; m_waitrequest = 1'b0;
      end else begin
        if (sl_pend) begin
          if (sl_lat == 0) begin
            m_readdatavalid = 1'b1; m_readdata = sl_data; sl_pend = 1'b0;
          end else sl_lat--;
        end else if (stray_en && !drop_reads && $urandom_range(0, 3) == 0) begin
          m_readdatavalid = 1'b1; m_readdata = $urandom;
        end
        if (m_read || m_write) begin
          if (sl_stall < 0) sl_stall = $urandom_range(0, max_stall);
          if (sl_stall > 0) begin
            m_waitrequest = 1'b1; sl_stall--;
          end else begin
            m_waitrequest = 1'b0; sl_stall = -1;
            if (m_write) bus_write(m_address, m_writedata);
            else if (!drop_reads) begin
              sl_pend = 1'b1; sl_lat = $urandom_range(0, 2); sl_data = mem_rd(m_address);
            end
          end
        end else m_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: every command taken by the slave is popped against the expected queue.
  initial begin
    logic [64:0] act;
    forever begin
      @(negedge clk);
      if (reset_n && (m_read || m_write)) begin
        strobe_cycles++;
        if (m_read && m_write) check("rd_wr_exclusive", {m_read, m_write}, 2'b10);
        if (!m_waitrequest) begin
          act = {m_write, m_address, m_write ? m_writedata : 32'd0};
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_unexpected actual=%0h required=none", act);
          end else check("bus_txn", act, exp_q.pop_front());
        end
      end
    end
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  // Reference: the full transaction list a run of cnt pairs must produce.
  task automatic model_run(input logic [31:0] src, input logic [31:0] dst, input int cnt);
    logic [31:0] a, b;
    for (int i = 0; i < cnt; i++) begin
      a = mem_rd(src + 32'(8 * i));
      b = mem_rd(src + 32'(8 * i) + 32'd4);
      exp_q.push_back({1'b0, src + 32'(8 * i), 32'd0});
      exp_q.push_back({1'b0, src + 32'(8 * i) + 32'd4, 32'd0});
      exp_q.push_back({1'b1, ACC, a});
      exp_q.push_back({1'b1, ACC + 32'd4, b});
      exp_q.push_back({1'b1, ACC + 32'd12, 32'd0});
      exp_q.push_back({1'b0, ACC + 32'd16, 32'd0});
      exp_q.push_back({1'b1, dst + 32'(4 * i), fadd(a, b)});
    end
  endtask

  task automatic wait_done(input string name, output logic [31:0] st);
    int n;
    n = 0;
    st = 32'd0;
    while (n < 3000 && !st[2]) begin
      csr_rd(2'd3, st);
      n++;
    end
    if (!st[2]) check({name, "_done_timeout"}, st, 32'h4);
  endtask

  task automatic run_pairs(input string name, input logic [31:0] src, input logic [31:0] dst,
                           input int cnt, input bit ien, input bit busy_poke);
    logic [31:0] st, d;
    logic [31:0] exp_res [$];
    for (int i = 0; i < cnt; i++) begin
      mem[src + 32'(8 * i)]          = rand_float();
      mem[src + 32'(8 * i) + 32'd4]  = rand_float();
      exp_res.push_back(fadd(mem[src + 32'(8 * i)], mem[src + 32'(8 * i) + 32'd4]));
    end
    csr_wr(2'd0, src); csr_wr(2'd1, dst); csr_wr(2'd2, 32'(cnt));
    model_run(src, dst, cnt);
    csr_wr(2'd3, {29'd0, 1'b1, ien, 1'b1});
    check({name, "_irq_after_start"}, irq, 1'b0);
    if (busy_poke) begin
      csr_wr(2'd0, 32'hDEAD_0000);
      csr_wr(2'd2, 32'd7);
      csr_wr(2'd3, {30'd0, ien, 1'b1});
    end
    wait_done(name, st);
    check({name, "_status"}, st, {16'(cnt), 12'd0, 1'b0, 1'b1, ien, 1'b0});
    for (int i = 0; i < cnt; i++) check({name, "_dst_word"}, mem_rd(dst + 32'(4 * i)), exp_res[i]);
    check({name, "_exp_q_empty"}, exp_q.size(), 0);
    if (busy_poke) begin
      csr_rd(2'd0, d);
      check({name, "_src_kept"}, d, src);
      csr_rd(2'd2, d);
      check({name, "_count_kept"}, d, 32'(cnt));
    end
  endtask

  initial begin
    logic [31:0] d;
    int s0, n;
    csr_address = 2'd0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {m_read, m_write, irq, m_address, m_writedata, csr_readdata},
          {3'b000, 96'd0});
    check("reset_state", dbg_state, 4'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    csr_rd(2'd3, d); check("reset_status", d, 32'd0);
    csr_rd(2'd2, d); check("reset_count", d, 32'd0);

    // Directed 1.0 + 2.0 pair.
    mem[32'h100] = 32'h3F80_0000;
    mem[32'h104] = 32'h4000_0000;
    csr_wr(2'd0, 32'h100); csr_wr(2'd1, 32'h203); csr_wr(2'd2, 32'd1);
    csr_rd(2'd1, d); check("dst_low_bits_forced", d, 32'h200);
    model_run(32'h100, 32'h200, 1);
    csr_wr(2'd3, 32'h5);
    wait_done("directed", d);
    check("directed_status", d, 32'h0001_0004);
    check("directed_result", mem_rd(32'h200), 32'h4040_0000);
    check("directed_exp_q_empty", exp_q.size(), 0);

    // Randomized runs with stalls, stray responses, busy writes and address wrap.
    max_stall = 5;
    stray_en = 1'b1;
    run_pairs("rand4", 32'h2000, 32'h8000, 4, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++)
      run_pairs("randn", 32'h3000 + 32'(r * 32'h400), 32'h9000 + 32'(r * 32'h100),
                $urandom_range(1, 6), 1'b0, 1'b0);
    run_pairs("wrap", 32'hFFFF_FFF8, 32'h5000, 2, 1'b0, 1'b0);

    // COUNT=0: done immediately, no bus traffic.
    csr_wr(2'd2, 32'd0);
    s0 = strobe_cycles;
    csr_wr(2'd3, 32'h5);
    csr_rd(2'd3, d);
    check("count0_status", d, 32'h0000_0004);
    repeat (5) @(posedge clk);
    #1;
    check("count0_no_traffic", strobe_cycles - s0, 0);

    // Interrupt raise and done-clear.
    run_pairs("irq", 32'h4000, 32'hA000, 1, 1'b1, 1'b0);
    check("irq_high", irq, 1'b1);
    csr_wr(2'd3, 32'h6);
    check("irq_cleared", irq, 1'b0);
    csr_rd(2'd3, d);
    check("irq_status_after_clear", d, 32'h0001_0002);

    // Reset in WR_B: strobes drop at once, nothing resumes.
    max_stall = 0;
    stray_en = 1'b0;
    mem[32'h6000] = rand_float(); mem[32'h6004] = rand_float();
    mem[32'h6008] = rand_float(); mem[32'h600C] = rand_float();
    csr_wr(2'd0, 32'h6000); csr_wr(2'd1, 32'hB000); csr_wr(2'd2, 32'd2);
    model_run(32'h6000, 32'hB000, 2);
    csr_wr(2'd3, 32'h5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_write && m_address == ACC + 32'd4) && n < 200);
    check("reached_wr_b", {m_write, m_address}, {1'b1, ACC + 32'd4});
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_drops_strobes", {m_read, m_write}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    csr_rd(2'd3, d); check("post_reset_status", d, 32'd0);
    csr_rd(2'd0, d); check("post_reset_src", d, 32'd0);
    s0 = strobe_cycles;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_no_traffic", strobe_cycles - s0, 0);

`ifdef DMA_FEEDER_TIMEOUT_EN
    // Missing read response: watchdog aborts with err.
    drop_reads = 1'b1;
    csr_wr(2'd0, 32'h7000); csr_wr(2'd2, 32'd1);
    exp_q.push_back({1'b0, 32'h7000, 32'd0});
    csr_wr(2'd3, 32'h5);
    repeat (1000) @(posedge clk);
    #1;
    csr_rd(2'd3, d); check("timeout_still_busy", d, 32'h0000_0001);
    repeat (40) @(posedge clk);
    #1;
    csr_rd(2'd3, d); check("timeout_err_done", d, 32'h0000_000C);
    check("timeout_exp_q_empty", exp_q.size(), 0);
    drop_reads = 1'b0;
`endif

    check("final_exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
